// File: rtl/fp_result_pack_stage.sv
// fp_result_pack_stage: registered FP result classify/pack stage with sticky flags; define FP_OVERFLOW_SATURATE_EN to saturate overflow to max finite
module fp_result_pack_stage #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_special,
    input  logic                            in_sign,
    input  logic [EXP_WIDTH+1:0]            in_exponent,
    input  logic [FRAC_WIDTH:0]             in_fraction,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   out_result,
    output logic [3:0]                      out_flags,
    output logic [TAG_WIDTH-1:0]            out_tag,
    input  logic                            flags_clear,
    output logic [3:0]                      sticky_flags
);
    localparam int XW = EXP_WIDTH + 2;
    localparam int RW = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam logic [XW-1:0] EXP_TOP = {2'b00, {EXP_WIDTH{1'b1}}};
    typedef enum logic [1:0] {SP_NORMAL, SP_ZERO, SP_INF, SP_QNAN} special_e;
    logic              accept, is_zero, is_ovf, is_unf;
    logic [RW-1:0]     norm_res, inf_res, ovf_res, szero_res, qnan_res, pack_res;
    logic [3:0]        pack_flags;
    logic              valid_d, valid_q;
    logic [RW-1:0]     result_d, result_q;
    logic [3:0]        flags_d, flags_q, sticky_d, sticky_q;
    logic [TAG_WIDTH-1:0] tag_d, tag_q;
    always_comb begin
        is_zero   = in_fraction == '0;
        is_ovf    = ~in_exponent[XW-1] && in_exponent >= EXP_TOP;
        is_unf    = in_exponent == '0 || in_exponent[XW-1];
        norm_res  = {in_sign, in_exponent[EXP_WIDTH-1:0], in_fraction[FRAC_WIDTH-1:0]};
        inf_res   = {in_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        szero_res = {in_sign, {(RW-1){1'b0}}};
        qnan_res  = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
`ifdef FP_OVERFLOW_SATURATE_EN
        ovf_res   = {in_sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {FRAC_WIDTH{1'b1}}};
`else
        ovf_res   = inf_res;
`endif
        pack_res = in_special == SP_QNAN ? qnan_res :
                   in_special == SP_INF  ? inf_res :
                   in_special == SP_ZERO ? szero_res :
                   is_zero ? '0 : is_ovf ? ovf_res : is_unf ? szero_res : norm_res;
        pack_flags = in_special == SP_QNAN ? 4'b1000 :
                     in_special != SP_NORMAL ? 4'b0000 :
                     is_zero ? 4'b0001 : is_ovf ? 4'b0100 : is_unf ? 4'b0010 : 4'b0000;
        in_ready = ~valid_q | out_ready;
        accept   = in_valid & in_ready;
        valid_d  = accept | (valid_q & ~out_ready);
        result_d = accept ? pack_res : result_q;
        flags_d  = accept ? pack_flags : flags_q;
        tag_d    = accept ? in_tag : tag_q;
        // a result accepted alongside a clear keeps its flags
        sticky_d = (flags_clear ? 4'b0000 : sticky_q) | (accept ? pack_flags : 4'b0000);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            tag_q    <= '0;
            sticky_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            tag_q    <= tag_d;
            sticky_q <= sticky_d;
        end
    end
    assign out_valid    = valid_q;
    assign out_result   = result_q;
    assign out_flags    = flags_q;
    assign out_tag      = tag_q;
    assign sticky_flags = sticky_q;
endmodule

// File: doc/fp_result_pack_stage.md
Name: fp_result_pack_stage

Overview:
- Parametrised, registered successor to the combinational result-select logic in the FPU back end.
- Takes the normalised result (sign, biased signed exponent, fraction with hidden bit) plus a special-case request from the execute pipeline.
- Classifies the result as zero, overflow or underflow, then packs the final IEEE-style word into one valid/ready pipeline stage.
- Accumulates sticky exception flags until software clears them.

Parameters:
- EXP_WIDTH, 8, stored exponent field width.
- FRAC_WIDTH, 23, stored fraction field width (hidden bit excluded).
- TAG_WIDTH, 4, opaque tag carried alongside each result (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept.
- in_special  input  2  0=NORMAL, 1=ZERO, 2=INF, 3=QNAN.
- in_sign  input  1  result sign.
- in_exponent  input  EXP_WIDTH+2  biased exponent, two's complement.
- in_fraction  input  FRAC_WIDTH+1  fraction; MSB is hidden bit.
- in_tag  input  TAG_WIDTH  passthrough tag.
- out_valid  output  1  packed result valid.
- out_ready  input  1  downstream accepts.
- out_result  output  1+EXP_WIDTH+FRAC_WIDTH  {sign, exponent, fraction}.
- out_flags  output  4  per-result {invalid, overflow, underflow, zero}.
- out_tag  output  TAG_WIDTH  tag of the held result.
- flags_clear  input  1  clear sticky flags.
- sticky_flags  output  4  OR of out_flags over all accepted results since the last clear/reset.

Behaviour:
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational, no bubble).
  - Accept when in_valid & in_ready.
  - On accept, out_* load next cycle and out_valid=1.
  - If out_valid & out_ready and no accept, out_valid=0 next cycle.
  - Held out_* stay stable while out_valid & ~out_ready.
- Latency: exactly 1 cycle; throughput 1 per cycle under continuous out_ready.
- Classification (NORMAL only), evaluated on the input side:
  - zero = in_fraction == 0.
  - overflow = in_exponent MSB==0 and in_exponent ≥ 2^EXP_WIDTH−1.
  - underflow = in_exponent == 0 or in_exponent MSB==1 (negative).
  - Priority: zero > overflow > underflow > normal.
- Packing, as {sign, exponent field, fraction field}:
  - NORMAL/zero: {0, 0, 0}; flags zero=1. Sign is forced to 0.
  - NORMAL/overflow: {in_sign, all ones, 0}; flags overflow=1.
  - NORMAL/underflow: {in_sign, 0, 0}; flags underflow=1.
  - NORMAL/normal: {in_sign, in_exponent[EXP_WIDTH-1:0], in_fraction[FRAC_WIDTH-1:0]}; flags 0.
  - ZERO: {in_sign, 0, 0}; flags 0 (signed zero preserved; no zero flag).
  - INF: {in_sign, all ones, 0}; flags 0.
  - QNAN: {0, all ones, MSB 1 rest 0}; flags invalid=1.
  - For ZERO, INF and QNAN, in_exponent and in_fraction are ignored; no bound checks are applied.
- Sticky flags:
  - sticky_next = (flags_clear ? 0 : sticky) | (accept ? new_flags : 0).
  - When clear and accept coincide, the new result's flags survive the clear.
- Reset (synchronous, highest priority over every event):
  - out_valid=0, out_result=0, out_flags=0, out_tag=0, sticky_flags=0.
  - A result held mid-stall is dropped.
  - in_ready is 1 in the cycle after reset.
- Exponent boundaries (EXP_WIDTH=8):
  - 254 is normal; 255 overflows; 511 overflows.
  - −1 (0x3FF) and −512 (0x200) underflow.

Optional Feature:
- Macro: FP_OVERFLOW_SATURATE_EN.
- Defined: NORMAL/overflow packs the largest finite magnitude, {in_sign, all ones except LSB=0, all ones}. The overflow flag is still set. INF requests still produce infinity.
- Undefined: overflow packs infinity as specified above.

Test Plan:
- Reset high 2 cycles with in_valid=1 → out_valid=0, out_result=0, sticky_flags=0; in_ready=1 the first cycle after reset.
- NORMAL, sign 1, exp 127, frac 0x800000 → next cycle out_result=0xBF800000, out_flags=0; tag 5 in → out_tag=5.
- NORMAL exp 255, sign 0 → 0x7F800000, flags=0100 (0x7F7FFFFF with FP_OVERFLOW_SATURATE_EN). NORMAL exp 0x3FF, sign 1 → 0x80000000, flags=0010. NORMAL frac 0, exp 300 → 0x00000000, flags=0001 (zero beats overflow).
- QNAN, sign 1 → 0x7FC00000, flags=1000. ZERO, sign 1 → 0x80000000, flags=0000.
- Back-to-back stream of 4 results with out_ready low for 3 cycles mid-stream:
  - out_result/out_tag are held stable while stalled.
  - in_ready=0 while out_valid & ~out_ready.
  - No result is lost or duplicated; order is preserved.
- Stream an overflow result then an invalid result → sticky_flags=1100. Assert flags_clear in the same cycle an underflow result is accepted → sticky_flags=0010. Next cycle with no accept and no clear → remains 0010.
